// File: rtl/ps2_scan_ctrl.sv
// Pops PS/2 bytes from the key FIFO, folds E0/F0 prefixes into one key event, tracks held key/press count.
// Latency: pop strobe 1 cycle after fifo_ready is seen in IDLE, ev_valid 3 cycles after. A stalled event blocks further pops.
module ps2_scan_ctrl #(
    parameter int CNT_MAX        = 99,
    parameter int PREFIX_TIMEOUT = 2_000_000,
    parameter int TO_W           = 21
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] fifo_data,
    input  logic       fifo_ready,
    input  logic       fifo_overflow,
    output logic       fifo_next_n,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic       ev_repeat,
    output logic       key_down,
    output logic [8:0] last_key,
    output logic [7:0] press_cnt,
    output logic       ovf_flag,
    input  logic       clr
);

    typedef enum logic [1:0] {S_IDLE, S_POP, S_SETTLE, S_EMIT} state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(PREFIX_TIMEOUT - 1);
    localparam logic [7:0]      CNT_SAT = 8'(CNT_MAX);

    state_t          r_state;
    logic [7:0]      r_byte;
    logic            r_ext_pend;
    logic            r_brk_pend;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_next_n;
    logic            r_ev_valid;
    logic [7:0]      r_ev_code;
    logic            r_ev_ext;
    logic            r_ev_break;
    logic            r_ev_repeat;
    logic            r_key_down;
    logic [8:0]      r_last_key;
    logic [7:0]      r_press_cnt;
    logic            r_ovf;

    logic       w_hs;
    logic       w_settle_rep;
    logic [8:0] w_ev_key;
    logic       w_new_press;

    assign w_hs         = r_ev_valid & ev_ready;
    assign w_settle_rep = ~r_brk_pend & r_key_down & ({r_ext_pend, r_byte} == r_last_key);
    assign w_ev_key     = {r_ev_ext, r_ev_code};
    assign w_new_press  = w_hs & ~r_ev_break & ~r_ev_repeat;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_byte      <= 8'h00;
            r_ext_pend  <= 1'b0;
            r_brk_pend  <= 1'b0;
            r_to_cnt    <= '0;
            r_next_n    <= 1'b1;
            r_ev_valid  <= 1'b0;
            r_ev_code   <= 8'h00;
            r_ev_ext    <= 1'b0;
            r_ev_break  <= 1'b0;
            r_ev_repeat <= 1'b0;
            r_key_down  <= 1'b0;
            r_last_key  <= 9'h000;
            r_press_cnt <= 8'h00;
            r_ovf       <= 1'b0;
        end else begin
            r_next_n <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (fifo_ready) begin
                        r_byte   <= fifo_data;
                        r_to_cnt <= '0;
                        r_next_n <= 1'b0;
                        r_state  <= S_POP;
                    end else if (r_ext_pend | r_brk_pend) begin
                        // A prefix with no follow-up byte is stale; drop it.
                        if (r_to_cnt == TO_LAST) begin
                            r_ext_pend <= 1'b0;
                            r_brk_pend <= 1'b0;
                            r_to_cnt   <= '0;
                        end else begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                        end
                    end
                end
                S_POP: r_state <= S_SETTLE;
                S_SETTLE: begin
                    r_state <= S_IDLE;
                    case (r_byte)
                        8'hE0: r_ext_pend <= 1'b1;
                        8'hF0: r_brk_pend <= 1'b1;
                        8'h00, 8'hFF: begin
                            r_ext_pend <= 1'b0;
                            r_brk_pend <= 1'b0;
                        end
                        default: begin
                            r_ev_code   <= r_byte;
                            r_ev_ext    <= r_ext_pend;
                            r_ev_break  <= r_brk_pend;
                            r_ev_repeat <= w_settle_rep;
                            r_ev_valid  <= 1'b1;
                            r_state     <= S_EMIT;
                        end
                    endcase
                end
                S_EMIT: begin
                    if (ev_ready) begin
                        r_ev_valid <= 1'b0;
                        r_ext_pend <= 1'b0;
                        r_brk_pend <= 1'b0;
                        r_state    <= S_IDLE;
                        if (r_ev_break) begin
                            if (w_ev_key == r_last_key) r_key_down <= 1'b0;
                        end else if (!r_ev_repeat) begin
                            r_last_key <= w_ev_key;
                            r_key_down <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (clr)                                    r_press_cnt <= 8'h00;
            else if (w_new_press && r_press_cnt < CNT_SAT) r_press_cnt <= r_press_cnt + 8'd1;

            if (clr)                r_ovf <= 1'b0;
            else if (fifo_overflow) r_ovf <= 1'b1;
        end
    end

    assign fifo_next_n = r_next_n;
    assign ev_valid    = r_ev_valid;
    assign ev_code     = r_ev_code;
    assign ev_ext      = r_ev_ext;
    assign ev_break    = r_ev_break;
    assign ev_repeat   = r_ev_repeat;
    assign key_down    = r_key_down;
    assign last_key    = r_last_key;
    assign press_cnt   = r_press_cnt;
    assign ovf_flag    = r_ovf;

endmodule

// File: doc/ps2_scan_ctrl.md
# ps2_scan_ctrl

Sequencing controller between the `ps2_key` receive FIFO and the keyboard consumers (scan-code/ASCII display, press counter). It pops bytes from the FIFO with the `nextdata_n` handshake and parses `E0`/`F0` prefixes into single key events. It emits each event on a valid/ready port and tracks the held-key state, press count and sticky overflow. Consumers never touch the FIFO directly.

## Interface
- `CNT_MAX`, default 99: saturation value of `press_cnt`.
- `PREFIX_TIMEOUT`, default 2_000_000: number of idle clk cycles after which a dangling `E0`/`F0` prefix is discarded.
- `TO_W`, default 21: width of the timeout counter. Must satisfy 2^TO_W > PREFIX_TIMEOUT.

Ports:
- `clk`  in  1  clock; all state is updated on its rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `fifo_data`  in  8  head byte of the `ps2_key` FIFO; valid while `fifo_ready`=1.
- `fifo_ready`  in  1  FIFO non-empty.
- `fifo_overflow`  in  1  FIFO overflow indication.
- `fifo_next_n`  out  1  active-low pop strobe; one cycle low per pop; registered.
- `ev_valid`  out  1  event available.
- `ev_ready`  in  1  consumer accepts the event.
- `ev_code`  out  8  scan code of the event; excludes prefix bytes.
- `ev_ext`  out  1  event was preceded by `E0`.
- `ev_break`  out  1  release event (preceded by `F0`).
- `ev_repeat`  out  1  make event for a key that is already down (typematic repeat).
- `key_down`  out  1  a tracked key is currently held.
- `last_key`  out  9  {ext, code} of the last make event.
- `press_cnt`  out  8  number of new presses, saturating at CNT_MAX.
- `ovf_flag`  out  1  sticky copy of `fifo_overflow`.
- `clr`  in  1  single-cycle clear of `press_cnt` and `ovf_flag`.

## Operation
The FSM has four states.
- **IDLE**
  - If `fifo_ready`=1: latch `fifo_data` into `byte_r`, clear the timeout counter, go to POP.
  - Otherwise stay in IDLE.
- **POP**
  - `fifo_next_n`=0 for exactly this cycle.
  - Go to SETTLE. This gives the FIFO read pointer one edge to advance.
- **SETTLE**
  - `fifo_next_n`=1. Decode `byte_r`:
    - `E0`: set `ext_pend`, go to IDLE.
    - `F0`: set `brk_pend`, go to IDLE.
    - `00` or `FF` (keyboard error/overrun): clear both pend flags, emit nothing, go to IDLE.
    - Any other byte: load `ev_code`=`byte_r`, `ev_ext`=`ext_pend`, `ev_break`=`brk_pend`, set `ev_repeat`, go to EMIT.
- **EMIT**
  - `ev_valid`=1; all `ev_*` outputs are held stable until the handshake.
  - On `ev_valid`&`ev_ready`: clear both pend flags, update key tracking, go to IDLE.

Key tracking, applied at the EMIT handshake:
- **Make, not repeat:** `last_key`<={ext,code}; `key_down`<=1; `press_cnt`+1, saturating at CNT_MAX.
- **Make with `key_down`=1 and {ext,code}==`last_key`:** `ev_repeat`=1; counter unchanged.
- **Make of a different key while one is down:** counts as a new press; `last_key` is replaced.
- **Break matching `last_key`:** `key_down`<=0.
- **Break not matching:** event is still emitted; tracking unchanged.

Prefix timeout:
- The counter runs only in IDLE while `ext_pend`|`brk_pend` is set.
- When it reaches PREFIX_TIMEOUT-1, both pend flags are cleared and the counter returns to 0.

Overflow and clear:
- `ovf_flag` is set on any cycle with `fifo_overflow`=1.
- `clr` clears `ovf_flag` and `press_cnt`.
- If `clr` coincides with an increment or with an overflow set, `clr` wins.

## Timing
- **Reset values:** state=IDLE, `fifo_next_n`=1, `ev_valid`=0, `ev_code`=00, `ev_ext`/`ev_break`/`ev_repeat`=0, `key_down`=0, `last_key`=000, `press_cnt`=0, `ovf_flag`=0, pend flags=0, timeout counter=0.
- **Reset mid-operation:** reset asserted in any state returns to IDLE next cycle. A pending event is dropped and no pop is issued.
- **Latency:** with `fifo_ready` sampled high in IDLE at cycle t:
  - `fifo_next_n` is low at t+1.
  - `ev_valid` rises at t+3.
  - With `ev_ready` held at 1, the FSM is back in IDLE at t+4.
- **Throughput:**
  - Minimum of 4 cycles per code byte; 3 cycles per prefix byte.
  - A break of an extended key (E0 F0 xx) produces a single event 3+3+3 cycles after the first byte.
- **Pop rule:** exactly one pop per byte, never issued while `fifo_ready`=0. `fifo_data` is never sampled outside IDLE.
- **Backpressure:** a stalled EMIT does not pop. The FIFO fills, and any overflow shows in `ovf_flag`.

## Test plan
- **Single make:** FIFO delivers `1C`, `ev_ready`=1 → `fifo_next_n` has one low pulse; event `ev_code`=1C, ext=0, break=0; `press_cnt`=1, `key_down`=1, `last_key`=01C.
- **Extended press and release:** `E0 75`, then `E0 F0 75` → two events, code 75, ext=1, break 0 then 1. `key_down` returns to 0; exactly 5 pops; `press_cnt`=1.
- **Typematic repeat:** `1C 1C 1C F0 1C` → three make events with repeat flags 0,1,1 and one break event; `press_cnt`=1.
- **Saturation and clear:** 120 distinct make/break pairs → `press_cnt`=99 (CNT_MAX). Pulse `clr` in the same cycle as an EMIT handshake → `press_cnt`=0 and `ovf_flag`=0.
- **Backpressure and overflow:** `ev_ready`=0 for 200 cycles while bytes keep arriving → `ev_valid` held with stable fields; no pops in EMIT; `fifo_overflow` pulse → `ovf_flag`=1 until `clr`. A byte `FF` → no event, pend flags cleared.
- **Prefix timeout:** `F0` then no data for PREFIX_TIMEOUT cycles (bench uses PREFIX_TIMEOUT=50), then `1C` → make event with break=0. Separately, reset asserted during EMIT → `ev_valid`=0 next cycle and no pop.
